// File: rtl/control_unit.sv
// Control unit for the 8-bit accumulator CPU: Moore FSM sequencing fetch, decode
// and execute, driving every datapath strobe, bus select, ALU select and memory write.
module control_unit #(
  parameter int unsigned OPC_W = 8,
  parameter int unsigned CCR_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OPC_W-1:0] IR,
  input  logic [CCR_W-1:0] CCR_Result,
  output logic             IR_Load,
  output logic             MAR_Load,
  output logic             PC_Load,
  output logic             PC_Inc,
  output logic             A_Load,
  output logic             B_Load,
  output logic             CCR_Load,
  output logic [3:0]       ALU_Sel,
  output logic [1:0]       Bus1_Sel,
  output logic [1:0]       Bus2_Sel,
  output logic             write,
  output logic             halted
);

  localparam logic [OPC_W-1:0] OP_LDA_IMM = 'h86;
  localparam logic [OPC_W-1:0] OP_LDA_DIR = 'h87;
  localparam logic [OPC_W-1:0] OP_LDB_IMM = 'h88;
  localparam logic [OPC_W-1:0] OP_LDB_DIR = 'h89;
  localparam logic [OPC_W-1:0] OP_STA_DIR = 'h96;
  localparam logic [OPC_W-1:0] OP_STB_DIR = 'h97;
  localparam logic [OPC_W-1:0] OP_ADD     = 'h42;
  localparam logic [OPC_W-1:0] OP_SUB     = 'h43;
  localparam logic [OPC_W-1:0] OP_AND     = 'h44;
  localparam logic [OPC_W-1:0] OP_OR      = 'h45;
  localparam logic [OPC_W-1:0] OP_INCA    = 'h46;
  localparam logic [OPC_W-1:0] OP_DECA    = 'h47;
  localparam logic [OPC_W-1:0] OP_BRA     = 'h20;
  localparam logic [OPC_W-1:0] OP_BMI     = 'h21;
  localparam logic [OPC_W-1:0] OP_BEQ     = 'h23;
  localparam logic [OPC_W-1:0] OP_BCS     = 'h25;
  localparam logic [OPC_W-1:0] OP_HLT     = 'hFF;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 0;

  localparam logic [1:0] B1_PC  = 2'b00;
  localparam logic [1:0] B1_A   = 2'b01;
  localparam logic [1:0] B1_B   = 2'b10;
  localparam logic [1:0] B2_ALU = 2'b00;
  localparam logic [1:0] B2_B1  = 2'b01;
  localparam logic [1:0] B2_MEM = 2'b10;

  typedef enum logic [5:0] {
    S_FETCH_0, S_FETCH_1, S_FETCH_2, S_DECODE,
    S_LDA_IMM_0, S_LDA_IMM_1, S_LDA_IMM_2,
    S_LDB_IMM_0, S_LDB_IMM_1, S_LDB_IMM_2,
    S_LDA_DIR_0, S_LDA_DIR_1, S_LDA_DIR_2, S_LDA_DIR_3, S_LDA_DIR_4,
    S_LDB_DIR_0, S_LDB_DIR_1, S_LDB_DIR_2, S_LDB_DIR_3, S_LDB_DIR_4,
    S_STA_DIR_0, S_STA_DIR_1, S_STA_DIR_2, S_STA_DIR_3,
    S_STB_DIR_0, S_STB_DIR_1, S_STB_DIR_2, S_STB_DIR_3,
    S_ADD, S_SUB, S_AND, S_OR, S_INCA, S_DECA,
    S_BRA_0, S_BRA_1, S_BRA_2, S_BR_SKIP, S_HALT
  } state_t;

  state_t r_state;

  // Overflow is never a branch condition here.
  logic w_unused_v;
  assign w_unused_v = CCR_Result[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH_0;
    end else begin
      case (r_state)
        S_FETCH_0: r_state <= S_FETCH_1;
        S_FETCH_1: r_state <= S_FETCH_2;
        S_FETCH_2: r_state <= S_DECODE;
        S_DECODE: begin
          case (IR)
            OP_LDA_IMM: r_state <= S_LDA_IMM_0;
            OP_LDB_IMM: r_state <= S_LDB_IMM_0;
            OP_LDA_DIR: r_state <= S_LDA_DIR_0;
            OP_LDB_DIR: r_state <= S_LDB_DIR_0;
            OP_STA_DIR: r_state <= S_STA_DIR_0;
            OP_STB_DIR: r_state <= S_STB_DIR_0;
            OP_ADD:     r_state <= S_ADD;
            OP_SUB:     r_state <= S_SUB;
            OP_AND:     r_state <= S_AND;
            OP_OR:      r_state <= S_OR;
            OP_INCA:    r_state <= S_INCA;
            OP_DECA:    r_state <= S_DECA;
            OP_BRA:     r_state <= S_BRA_0;
            OP_BMI:     r_state <= CCR_Result[FLAG_N] ? S_BRA_0 : S_BR_SKIP;
            OP_BEQ:     r_state <= CCR_Result[FLAG_Z] ? S_BRA_0 : S_BR_SKIP;
            OP_BCS:     r_state <= CCR_Result[FLAG_C] ? S_BRA_0 : S_BR_SKIP;
            OP_HLT:     r_state <= S_HALT;
            default:    r_state <= S_FETCH_0;
          endcase
        end
        S_LDA_IMM_0: r_state <= S_LDA_IMM_1;
        S_LDA_IMM_1: r_state <= S_LDA_IMM_2;
        S_LDB_IMM_0: r_state <= S_LDB_IMM_1;
        S_LDB_IMM_1: r_state <= S_LDB_IMM_2;
        S_LDA_DIR_0: r_state <= S_LDA_DIR_1;
        S_LDA_DIR_1: r_state <= S_LDA_DIR_2;
        S_LDA_DIR_2: r_state <= S_LDA_DIR_3;
        S_LDA_DIR_3: r_state <= S_LDA_DIR_4;
        S_LDB_DIR_0: r_state <= S_LDB_DIR_1;
        S_LDB_DIR_1: r_state <= S_LDB_DIR_2;
        S_LDB_DIR_2: r_state <= S_LDB_DIR_3;
        S_LDB_DIR_3: r_state <= S_LDB_DIR_4;
        S_STA_DIR_0: r_state <= S_STA_DIR_1;
        S_STA_DIR_1: r_state <= S_STA_DIR_2;
        S_STA_DIR_2: r_state <= S_STA_DIR_3;
        S_STB_DIR_0: r_state <= S_STB_DIR_1;
        S_STB_DIR_1: r_state <= S_STB_DIR_2;
        S_STB_DIR_2: r_state <= S_STB_DIR_3;
        S_BRA_0:     r_state <= S_BRA_1;
        S_BRA_1:     r_state <= S_BRA_2;
        S_HALT:      r_state <= S_HALT;
        default:     r_state <= S_FETCH_0;
      endcase
    end
  end

  // Outputs are a pure decode of state, forced quiet while reset is held.
  always_comb begin
    IR_Load  = 1'b0;
    MAR_Load = 1'b0;
    PC_Load  = 1'b0;
    PC_Inc   = 1'b0;
    A_Load   = 1'b0;
    B_Load   = 1'b0;
    CCR_Load = 1'b0;
    ALU_Sel  = '0;
    Bus1_Sel = B1_PC;
    Bus2_Sel = B2_ALU;
    write    = 1'b0;
    halted   = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH_0, S_LDA_IMM_0, S_LDB_IMM_0, S_LDA_DIR_0, S_LDB_DIR_0,
        S_STA_DIR_0, S_STB_DIR_0, S_BRA_0: begin
          Bus1_Sel = B1_PC;
          Bus2_Sel = B2_B1;
          MAR_Load = 1'b1;
        end
        S_FETCH_1, S_LDA_IMM_1, S_LDB_IMM_1, S_LDA_DIR_1, S_LDB_DIR_1,
        S_STA_DIR_1, S_STB_DIR_1, S_BR_SKIP: begin
          PC_Inc = 1'b1;
        end
        S_FETCH_2: begin
          Bus2_Sel = B2_MEM;
          IR_Load  = 1'b1;
        end
        S_LDA_IMM_2, S_LDA_DIR_4: begin
          Bus2_Sel = B2_MEM;
          A_Load   = 1'b1;
        end
        S_LDB_IMM_2, S_LDB_DIR_4: begin
          Bus2_Sel = B2_MEM;
          B_Load   = 1'b1;
        end
        S_LDA_DIR_2, S_LDB_DIR_2, S_STA_DIR_2, S_STB_DIR_2: begin
          Bus2_Sel = B2_MEM;
          MAR_Load = 1'b1;
        end
        S_STA_DIR_3: begin
          Bus1_Sel = B1_A;
          write    = 1'b1;
        end
        S_STB_DIR_3: begin
          Bus1_Sel = B1_B;
          write    = 1'b1;
        end
        S_ADD, S_SUB, S_AND, S_OR, S_INCA, S_DECA: begin
          Bus1_Sel = B1_A;
          Bus2_Sel = B2_ALU;
          A_Load   = 1'b1;
          CCR_Load = 1'b1;
          case (r_state)
            S_SUB:   ALU_Sel = 4'b0001;
            S_AND:   ALU_Sel = 4'b0010;
            S_OR:    ALU_Sel = 4'b0011;
            S_INCA:  ALU_Sel = 4'b0100;
            S_DECA:  ALU_Sel = 4'b0101;
            default: ALU_Sel = 4'b0000;
          endcase
        end
        S_BRA_2: begin
          Bus2_Sel = B2_MEM;
          PC_Load  = 1'b1;
        end
        S_HALT: begin
          halted = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
